stream_transpose: RTL
=====================

STREAM_TRANSPOSE -- requirements
Module: stream_transpose

Interface
REQ-001 SHALL have parameter SIZE_A, default 8, number of input rows per matrix (and elements per output beat).
REQ-002 SHALL have parameter SIZE_B, default 8, number of elements per input row (and output beats per matrix).
REQ-003 SHALL have parameter N_BITS, default 22, width of one matrix element.
REQ-004 SHALL use one clock, and reset SHALL be synchronous and active-low.
REQ-005 SHALL have port clk, input, 1 bit, the single clock, rising-edge active.
REQ-006 SHALL have port rst_n, input, 1 bit, synchronous active-low reset.
REQ-007 SHALL have port in_valid, input, 1 bit, in_row holds a valid row.
REQ-008 SHALL have port in_ready, output, 1 bit, block accepts a row this cycle.
REQ-009 SHALL have port in_row, input, [SIZE_B] x N_BITS, one matrix row, where element j is column j.
REQ-010 SHALL have port out_valid, output, 1 bit, out_row holds a valid transposed row.
REQ-011 SHALL have port out_ready, input, 1 bit, the downstream consumer accepts out_row.
REQ-012 SHALL have port out_row, output, [SIZE_A] x N_BITS, one row of the transposed matrix.
REQ-013 SHALL have port out_last, output, 1 bit, high on the final output beat of a matrix.
REQ-014 SHALL have port busy, output, 1 bit, high whenever the state is not FILL with zero rows stored.

Function
REQ-015 SHALL implement two states: FILL (the reset state) and DRAIN.
REQ-016 In FILL: in_ready=1 and out_valid=0; a handshake (in_valid and in_ready) SHALL store in_row into buffer row row_cnt and then increment row_cnt.
REQ-017 An accepted row with row_cnt==SIZE_A-1 SHALL set row_cnt to 0 and move the state to DRAIN on the next edge.
REQ-018 In DRAIN: in_ready=0 and out_valid=1; out_row[j] SHALL equal buffer[j][col_cnt] for j in 0..SIZE_A-1, driven combinationally from registered state.
REQ-019 In DRAIN, a handshake (out_valid and out_ready) SHALL increment col_cnt; out_last SHALL equal (col_cnt==SIZE_B-1) while in DRAIN and be 0 otherwise.
REQ-020 A handshake on the out_last beat SHALL clear col_cnt and move the state to FILL.
REQ-021 Latency: the first out_valid SHALL occur in the cycle after the final input row is accepted; the first input row of the next matrix SHALL be accepted no earlier than the cycle after the out_last handshake.
REQ-022 Throughput: at most one row in per cycle and one row out per cycle; with no stalls, one matrix takes SIZE_A+SIZE_B cycles.
REQ-023 in_valid asserted during DRAIN SHALL be ignored, with no buffer change and no counter change.
REQ-024 When out_ready is low in DRAIN, out_row, out_last and col_cnt SHALL hold stable.
REQ-025 out_valid SHALL NOT depend combinationally on out_ready, and in_ready SHALL NOT depend combinationally on in_valid.
REQ-026 Elements SHALL pass bit-exact with no arithmetic applied; row_cnt SHALL be $clog2(SIZE_A) bits wide and col_cnt $clog2(SIZE_B) bits wide, with a minimum of 1 bit each.
REQ-027 With SIZE_A=1, every accepted row SHALL trigger DRAIN; with SIZE_B=1, the DRAIN beat SHALL also be the out_last beat.

Reset
REQ-028 When rst_n=0 at a rising edge, the block SHALL set state=FILL and row_cnt=col_cnt=0, giving in_ready=1, out_valid=0, out_last=0 and busy=0 after that edge.
REQ-029 Buffer contents SHALL NOT be reset; out_row is a don't-care while out_valid=0.
REQ-030 A reset mid-FILL or mid-DRAIN SHALL discard the partial matrix, and no further output beats from that matrix SHALL appear.

Structure
REQ-031 A shared package SHALL hold the state enum type (FILL, DRAIN) and the default SIZE_A, SIZE_B and N_BITS constants used across the matrix blocks.
REQ-032 The block SHALL be a single module with no sub-module; the buffer SHALL be a register array of [SIZE_A][SIZE_B] elements, each N_BITS wide.

Verification
REQ-033 Verification SHALL cover a 3x4 matrix (SIZE_A=3, SIZE_B=4) with element value 16*i+j, streamed with out_ready held at 1; the bench SHALL check 4 output beats equal to {j, 16+j, 32+j} for j=0..3 and out_last only on beat 3.
REQ-034 Verification SHALL cover the 8x8 defaults with out_ready toggled 1-0-1 every cycle; the bench SHALL check out_row holds stable while stalled and all 64 elements match the transpose.
REQ-035 Verification SHALL cover in_valid held high continuously across two matrices; the bench SHALL check in_ready=0 throughout DRAIN, no corruption of the second matrix, and 2*(SIZE_A+SIZE_B) cycles total.
REQ-036 Verification SHALL cover rst_n=0 for 1 cycle after 2 of 4 DRAIN beats; the bench SHALL check out_valid=0 and in_ready=1 on the next cycle, and that a fresh matrix then transposes correctly.
REQ-037 Verification SHALL cover SIZE_B=1 with N_BITS=22 and all-ones data; the bench SHALL check a single output beat with out_last=1, value 22'h3FFFFF in every element, and a return to FILL.

Source files
------------

// File: rtl/stream_transpose_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// stream_transpose_pkg : state type and default geometry for matrix blocks
// Rev 1.0
// ---------------------------------------------------------------------------
package stream_transpose_pkg;

  typedef enum logic [0:0] {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } xpose_state_e;

  localparam int DEFAULT_SIZE_A = 8;
  localparam int DEFAULT_SIZE_B = 8;
  localparam int DEFAULT_N_BITS = 22;

  // Counter width for an index range of n entries, never narrower than 1 bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/stream_transpose.sv
`default_nettype none
// ---------------------------------------------------------------------------
// stream_transpose : accepts SIZE_A rows of SIZE_B elements, emits the
// transpose as SIZE_B rows of SIZE_A elements.                      Rev 1.0
// ---------------------------------------------------------------------------
module stream_transpose
  import stream_transpose_pkg::*;
#(
  parameter int SIZE_A = DEFAULT_SIZE_A,
  parameter int SIZE_B = DEFAULT_SIZE_B,
  parameter int N_BITS = DEFAULT_N_BITS
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [SIZE_B-1:0][N_BITS-1:0]  in_row,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [SIZE_A-1:0][N_BITS-1:0]  out_row,
  output logic                           out_last,
  output logic                           busy
);

  localparam int ROW_W = cnt_width(SIZE_A);
  localparam int COL_W = cnt_width(SIZE_B);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(SIZE_A - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(SIZE_B - 1);

  xpose_state_e      state, state_nxt;
  logic [ROW_W-1:0]  row_cnt, row_cnt_nxt;
  logic [COL_W-1:0]  col_cnt, col_cnt_nxt;
  logic [N_BITS-1:0] buffer [SIZE_A][SIZE_B];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= FILL;
      row_cnt <= '0;
      col_cnt <= '0;
    end else begin
      state   <= state_nxt;
      row_cnt <= row_cnt_nxt;
      col_cnt <= col_cnt_nxt;
    end
  end

  // Handshake outputs come from state only, never from the partner's strobe.
  always_comb begin
    state_nxt   = state;
    row_cnt_nxt = row_cnt;
    col_cnt_nxt = col_cnt;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    out_last    = 1'b0;
    case (state)
      FILL: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (row_cnt == ROW_LAST) begin
            row_cnt_nxt = '0;
            state_nxt   = DRAIN;
          end else begin
            row_cnt_nxt = row_cnt + ROW_W'(1);
          end
        end
      end
      DRAIN: begin
        out_valid = 1'b1;
        out_last  = (col_cnt == COL_LAST);
        if (out_ready) begin
          if (col_cnt == COL_LAST) begin
            col_cnt_nxt = '0;
            state_nxt   = FILL;
          end else begin
            col_cnt_nxt = col_cnt + COL_W'(1);
          end
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  // Storage is intentionally left out of reset; stale contents are never shown.
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      for (int j = 0; j < SIZE_B; j++) begin
        buffer[row_cnt][j] <= in_row[j];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < SIZE_A; i++) begin
      out_row[i] = buffer[i][col_cnt];
    end
  end

  assign busy = (state != FILL) || (row_cnt != '0);

endmodule
`default_nettype wire
